// File: rtl/ocmem_pkg.sv
// Shared types for the on-chip memory arbiter and ocmem_sp-based wrappers.
package ocmem_pkg;

  localparam int unsigned OCMEM_ADDR_W = 10;
  localparam int unsigned OCMEM_DATA_W = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ocmem_state_t;

  typedef struct packed {
    logic                    we;
    logic [OCMEM_ADDR_W-1:0] addr;
    logic [OCMEM_DATA_W-1:0] wdata;
  } ocmem_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] sel;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sel     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sel = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/ocmem_arb.sv
// Round-robin sequencer in front of a single-port on-chip memory, with an
// optional post-reset clear sweep and per-requester read response routing.
module ocmem_arb
  import ocmem_pkg::*;
#(
  parameter int unsigned          NUM_REQ    = 2,
  parameter int unsigned          MEM_WIDTH  = 32,
  parameter int unsigned          ADDR_WIDTH = 10,
  parameter int unsigned          MEM_DEPTH  = 1024,
  parameter int unsigned          INIT_EN    = 1,
  parameter logic [MEM_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*MEM_WIDTH-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [MEM_WIDTH-1:0]          rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          init_done_o,
  output logic                          mem_ce_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [MEM_WIDTH-1:0]          mem_d_o,
  input  logic [MEM_WIDTH-1:0]          mem_q_i
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(MEM_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam ocmem_state_t     RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;
  localparam logic             RST_DONE  = (INIT_EN != 0) ? 1'b0 : 1'b1;

  ocmem_state_t          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic                  init_done_q, init_done_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_WIDTH-1:0]  d_q, d_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [MEM_WIDTH-1:0]  sel_wdata;
  logic                  in_range;
  logic [NUM_REQ-1:0]    ready_c;
  logic                  ce_c;
  logic                  we_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid_i),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign sel_we    = req_we_i[gnt_idx];
  assign sel_addr  = req_addr_i[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata_i[32'(gnt_idx)*MEM_WIDTH +: MEM_WIDTH];
  assign in_range  = {1'b0, sel_addr} < DEPTH_C;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      init_done_q <= RST_DONE;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      d_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      d_q         <= d_d;
    end
  end

  // Out-of-range transfers are accepted but never reach the memory pins.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    init_done_d = init_done_q;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    addr_d      = addr_q;
    d_d         = d_q;
    ready_c     = '0;
    ce_c        = 1'b0;
    we_c        = 1'b0;
    case (state_q)
      ST_INIT: begin
        ce_c   = 1'b1;
        we_c   = 1'b1;
        addr_d = cnt_q[ADDR_WIDTH-1:0];
        d_d    = INIT_VALUE;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        ready_c = gnt;
        if (|gnt) begin
          ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
          if (in_range) begin
            ce_c   = 1'b1;
            we_c   = sel_we;
            addr_d = sel_addr;
            d_d    = sel_wdata;
          end
          if (!sel_we) begin
            rsp_valid_d = gnt;
            rsp_err_d   = !in_range;
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  // Memory pins and ready are forced low while reset is asserted.
  assign req_ready_o = ready_c & {NUM_REQ{rstn_i}};
  assign mem_ce_o    = ce_c & rstn_i;
  assign mem_we_o    = we_c & rstn_i;
  assign mem_addr_o  = rstn_i ? addr_d : '0;
  assign mem_d_o     = rstn_i ? d_d : '0;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = (|rsp_valid_q && !rsp_err_q) ? mem_q_i : '0;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_ocmem_arb.sv
// Randomized bench for ocmem_arb against a queue/array reference model plus a behavioural SRAM.
module tb_ocmem_arb;

  localparam int unsigned N     = 3;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1000;
  localparam logic [DW-1:0] INIT_V = 32'h5A5A_0F0F;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            init_done;
  logic            mem_ce;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_d;
  logic [DW-1:0]   mem_q = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ocmem_arb #(
    .NUM_REQ(N), .MEM_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH),
    .INIT_EN(1), .INIT_VALUE(INIT_V)
  ) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .init_done_o(init_done),
    .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_d_o(mem_d),
    .mem_q_i(mem_q)
  );

  // Single-port SRAM with registered read
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) sram[mem_addr] <= mem_d;
      else        mem_q <= sram[mem_addr];
    end
  end

  // Reference model state
  int            m_ptr;
  logic [DW-1:0] m_mem [0:DEPTH-1];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_d;
  logic [N-1:0]  e_rv;
  logic          e_err;
  logic [DW-1:0] e_data;
  logic [N-1:0]  obs_ready;
  logic [N-1:0]  obs_rv;
  logic          obs_err;
  logic [DW-1:0] obs_rdata;
  logic          obs_ce;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rspv"},  64'(rsp_valid), 64'd0);
    check({tag, "_err"},   64'(rsp_err),   64'd0);
    check({tag, "_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_done"},  64'(init_done), 64'd0);
    check({tag, "_cewe"},  64'({mem_ce, mem_we}), 64'd0);
    check({tag, "_addr"},  64'(mem_addr),  64'd0);
    check({tag, "_d"},     64'(mem_d),     64'd0);
  endtask

  // Requester 0 holds a read valid throughout; nothing may be accepted.
  task automatic sweep_check(input int count);
    for (int c = 0; c < count; c++) begin
      #1;
      req_valid = 3'b001;
      req_we    = '0;
      #1;
      check("sweep_ctl",  64'({mem_ce, mem_we, req_ready, init_done}), 64'({1'b1, 1'b1, 3'b000, 1'b0}));
      check("sweep_addr", 64'(mem_addr), 64'(c));
      check("sweep_d",    64'(mem_d),    64'(INIT_V));
      @(posedge clk);
    end
  endtask

  task automatic model_after_sweep();
    m_ptr  = 0;
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = INIT_V;
    m_addr = AW'(DEPTH - 1);
    m_d    = INIT_V;
    e_rv   = '0;
    e_err  = 1'b0;
    e_data = '0;
  endtask

  task automatic run_cycle(input logic [N-1:0] v, input logic [N-1:0] w,
                           input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    int            g;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    logic          gw;
    logic          exp_ce, exp_we;
    logic [N-1:0]  nrv;
    logic          nerr;
    logic [DW-1:0] ndata;
    #1;
    req_valid = v; req_we = w; req_addr = a; req_wdata = d;
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    check("rsp_err",   64'(rsp_err),   64'(e_err));
    if (e_rv != '0) check("rsp_rdata", 64'(rsp_rdata), 64'(e_data));
    check("init_done", 64'(init_done), 64'd1);
    g = -1;
    for (int k = 0; k < int'(N); k++) begin
      int idx;
      idx = (m_ptr + k) % int'(N);
      if (g < 0 && v[idx]) g = idx;
    end
    check("ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
    exp_ce = 1'b0; exp_we = 1'b0;
    nrv = '0; nerr = 1'b0; ndata = '0;
    if (g >= 0) begin
      ga = a[g*AW +: AW];
      gd = d[g*DW +: DW];
      gw = w[g];
      m_ptr = (g + 1) % int'(N);
      if (int'(ga) < int'(DEPTH)) begin
        exp_ce = 1'b1;
        exp_we = gw;
        m_addr = ga;
        m_d    = gd;
        if (gw) m_mem[ga] = gd;
      end
      if (!gw) begin
        nrv   = N'(1 << g);
        nerr  = int'(ga) >= int'(DEPTH);
        ndata = nerr ? '0 : m_mem[ga];
      end
    end
    check("mem_ce",   64'(mem_ce),   64'(exp_ce));
    check("mem_we",   64'(mem_we),   64'(exp_we));
    check("mem_addr", 64'(mem_addr), 64'(m_addr));
    check("mem_d",    64'(mem_d),    64'(m_d));
    obs_ready = req_ready; obs_rv = rsp_valid; obs_err = rsp_err;
    obs_rdata = rsp_rdata; obs_ce = mem_ce;
    e_rv = nrv; e_err = nerr; e_data = ndata;
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    logic [N-1:0]    seq_ready [0:5];
    logic [N-1:0]    seq_rv    [0:6];

    #12;
    check_quiet("reset");
    @(posedge clk);
    #1 rstn = 1'b1;

    // Sweep interrupted at address 300
    sweep_check(300);
    #1;
    check("mid_addr", 64'({mem_ce, mem_addr}), 64'({1'b1, 10'd300}));
    rstn = 1'b0;
    #1;
    check_quiet("rst_mid");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    sweep_check(int'(DEPTH));
    model_after_sweep();

    // First grant in the cycle after the final sweep write
    a = '0; d = '0;
    run_cycle(3'b001, 3'b000, a, d);
    check("first_grant", 64'(obs_ready), 64'(3'b001));

    // Write then read from requester 1
    a = '0; d = '0;
    a[1*AW +: AW] = 10'd5; d[1*DW +: DW] = 32'hDEAD_BEEF;
    run_cycle(3'b010, 3'b010, a, d);
    run_cycle(3'b010, 3'b000, a, d);
    #1;
    check("wr_rd_valid", 64'(rsp_valid), 64'(3'b010));
    check("wr_rd_data",  64'(rsp_rdata), 64'h0000_0000_DEAD_BEEF);
    check("wr_rd_err",   64'(rsp_err),   64'd0);

    // Fairness: requesters 0 and 1 both reading for six cycles
    for (int i = 0; i < 7; i++) begin
      a = '0;
      a[0 +: AW]  = AW'(i);
      a[AW +: AW] = 10'd5;
      run_cycle((i < 6) ? 3'b011 : 3'b000, 3'b000, a, '0);
      if (i < 6) seq_ready[i] = obs_ready;
      seq_rv[i] = obs_rv;
    end
    for (int i = 0; i < 6; i++) begin
      check("fair_grant", 64'(seq_ready[i]), (i % 2 == 0) ? 64'(3'b001) : 64'(3'b010));
      check("fair_rsp",   64'(seq_rv[i+1]),  (i % 2 == 0) ? 64'(3'b001) : 64'(3'b010));
    end

    // Pointer holds across idle cycles
    run_cycle(3'b001, 3'b000, '0, '0);
    repeat (3) run_cycle(3'b000, 3'b000, '0, '0);
    run_cycle(3'b011, 3'b000, '0, '0);
    check("idle_hold", 64'(obs_ready), 64'(3'b010));

    // Boundary addresses from requester 2
    a = '0; d = '0;
    a[2*AW +: AW] = 10'd1000;
    run_cycle(3'b100, 3'b000, a, d);
    check("oor_rd_ce", 64'(obs_ce), 64'd0);
    run_cycle(3'b000, 3'b000, a, d);
    check("oor_rsp", 64'({obs_rv, obs_err, obs_rdata}), 64'({3'b100, 1'b1, 32'h0}));
    a[2*AW +: AW] = 10'd1023; d[2*DW +: DW] = 32'h1234_5678;
    run_cycle(3'b100, 3'b100, a, d);
    check("oor_wr_ce", 64'(obs_ce), 64'd0);
    a[2*AW +: AW] = 10'd999;
    run_cycle(3'b100, 3'b100, a, d);
    run_cycle(3'b100, 3'b000, a, d);
    run_cycle(3'b000, 3'b000, a, d);
    check("last_word", 64'(obs_rdata), 64'h0000_0000_1234_5678);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [N-1:0] v, w;
      v = N'($urandom);
      w = N'($urandom);
      for (int r = 0; r < int'(N); r++) begin
        a[r*AW +: AW] = ($urandom_range(0, 99) < 80) ? AW'($urandom_range(0, 31))
                                                     : AW'($urandom_range(0, 1023));
        d[r*DW +: DW] = DW'($urandom);
      end
      run_cycle(v, w, a, d);
    end

    // Reset with a response pending
    a = '0;
    a[2*AW +: AW] = 10'd7;
    run_cycle(3'b100, 3'b000, a, '0);
    #1;
    check("pend_rsp", 64'(rsp_valid), 64'(3'b100));
    rstn = 1'b0;
    #1;
    check_quiet("rst_pend");
    @(posedge clk);
    #1 rstn = 1'b1;
    sweep_check(5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
